// File: rtl/sample_loader_pkg.sv
// Shared types, default sizing and bit-offset helper for the sample stream loader.
package sample_loader_pkg;

   localparam int DEFAULT_NUM_SAMPLES  = 32;
   localparam int DEFAULT_SAMPLE_W     = 8;
   localparam int DEFAULT_LANES        = 4;
   localparam int DEFAULT_NUM_CHANNELS = 3;
   localparam int CHECKSUM_W           = 16;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_WRITE,
      CAPTURE,
      ACK
   } state_t;

   // Bit offset of element (row, col) in a flat row-major array of width-bit elements.
   function automatic int unsigned slot_offset(input int unsigned row, input int unsigned col,
                                               input int unsigned row_len, input int unsigned width);
      return (row * row_len + col) * width;
   endfunction

endpackage

// File: rtl/sample_lane_adder.sv
// Sum of the first lane_count lanes of every channel, zero-extended to SUM_W bits.
module sample_lane_adder
   import sample_loader_pkg::*;
#(
   parameter int SAMPLE_W     = DEFAULT_SAMPLE_W,
   parameter int LANES        = DEFAULT_LANES,
   parameter int NUM_CHANNELS = DEFAULT_NUM_CHANNELS,
   parameter int N_W          = 3,
   parameter int SUM_W        = CHECKSUM_W
)(
   input  logic [NUM_CHANNELS*LANES*SAMPLE_W-1:0] lane_data,
   input  logic [N_W-1:0]                         lane_count,
   output logic [SUM_W-1:0]                       lane_sum
);

   localparam int LANE_W = NUM_CHANNELS * LANES * SAMPLE_W;
   localparam int OFF_W  = (LANE_W > 1) ? $clog2(LANE_W) : 1;

   logic [OFF_W-1:0] rd_off;

   always_comb begin
      lane_sum = '0;
      rd_off   = '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         for (int l = 0; l < LANES; l++) begin
            if (N_W'(l) < lane_count) begin
               rd_off   = OFF_W'(slot_offset(c, l, LANES, SAMPLE_W));
               lane_sum = lane_sum + SUM_W'(lane_data[rd_off +: SAMPLE_W]);
            end
         end
      end
   end

endmodule

// File: rtl/sample_stream_loader.sv
// Loads LANES samples per 4-phase transfer into per-channel arrays, with target,
// overflow flag and running checksum for HPS read-back.
//
// state      | meaning
// IDLE       | after reset, writes ignored until a session starts
// WAIT_WRITE | session open, waiting for iWriteSample
// CAPTURE    | one cycle: store accepted lanes, update count/checksum/done
// ACK        | oNextSample high until iWriteSample drops
module sample_stream_loader
   import sample_loader_pkg::*;
#(
   parameter int NUM_SAMPLES  = DEFAULT_NUM_SAMPLES,
   parameter int SAMPLE_W     = DEFAULT_SAMPLE_W,
   parameter int LANES        = DEFAULT_LANES,
   parameter int NUM_CHANNELS = DEFAULT_NUM_CHANNELS,
   parameter int CNT_W        = $clog2(NUM_SAMPLES + 1)
)(
   input  logic                                        iClock,
   input  logic                                        iReset_n,
   input  logic                                        iStartComm,
   input  logic [CNT_W-1:0]                            iSamplesToLoad,
   input  logic                                        iWriteSample,
   input  logic [NUM_CHANNELS*LANES*SAMPLE_W-1:0]      iLaneData,
   output logic                                        oNextSample,
   output logic                                        oPreparingNextSample,
   output logic [NUM_CHANNELS*NUM_SAMPLES*SAMPLE_W-1:0] oSamples,
   output logic [CNT_W-1:0]                            oSampleCount,
   output logic                                        oDone,
   output logic                                        oOverflow,
   output logic [CHECKSUM_W-1:0]                       oChecksum
);

   // One spare bit so count + n never wraps when NUM_SAMPLES is 2^k-1.
   localparam int CW     = CNT_W + 1;
   localparam int ARR_W  = NUM_CHANNELS * NUM_SAMPLES * SAMPLE_W;
   localparam int LANE_W = NUM_CHANNELS * LANES * SAMPLE_W;
   localparam int WO_W   = (ARR_W > 1) ? $clog2(ARR_W) : 1;
   localparam int RO_W   = (LANE_W > 1) ? $clog2(LANE_W) : 1;
   localparam logic [CW-1:0] FULL_C  = CW'(NUM_SAMPLES);
   localparam logic [CW-1:0] LANES_C = CW'(LANES);

   state_t                  state_q, state_d;
   logic                    start_prev_q, start_prev_d;
   logic [CW-1:0]           target_q, target_d;
   logic [CW-1:0]           count_q, count_d;
   logic [ARR_W-1:0]        samples_q, samples_d;
   logic [CHECKSUM_W-1:0]   checksum_q, checksum_d;
   logic                    done_q, done_d;
   logic                    ovf_q, ovf_d;
   logic                    next_q, next_d;
   logic                    busy_q, busy_d;

   logic                    start_edge;
   logic [CW-1:0]           target_req, target_res;
   logic [CW-1:0]           remain, n_take;
   logic [CHECKSUM_W-1:0]   lane_sum;
   logic [WO_W-1:0]         wr_off;
   logic [RO_W-1:0]         rd_off;

   assign start_edge = iStartComm & ~start_prev_q;
   assign target_req = {1'b0, iSamplesToLoad};
   assign target_res = ((target_req == '0) || (target_req > FULL_C)) ? FULL_C : target_req;
   assign remain     = target_q - count_q;
   assign n_take     = (remain > LANES_C) ? LANES_C : remain;

   sample_lane_adder #(
      .SAMPLE_W     (SAMPLE_W),
      .LANES        (LANES),
      .NUM_CHANNELS (NUM_CHANNELS),
      .N_W          (CW),
      .SUM_W        (CHECKSUM_W)
   ) u_lane_adder (
      .lane_data  (iLaneData),
      .lane_count (n_take),
      .lane_sum   (lane_sum)
   );

   always_comb begin
      state_d      = state_q;
      start_prev_d = iStartComm;
      target_d     = target_q;
      count_d      = count_q;
      samples_d    = samples_q;
      checksum_d   = checksum_q;
      done_d       = done_q;
      ovf_d        = ovf_q;
      next_d       = next_q;
      busy_d       = busy_q;
      wr_off       = '0;
      rd_off       = '0;

      if (start_edge) begin
         state_d    = WAIT_WRITE;
         target_d   = target_res;
         count_d    = '0;
         samples_d  = '0;
         checksum_d = '0;
         done_d     = 1'b0;
         ovf_d      = 1'b0;
         next_d     = 1'b0;
         busy_d     = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               next_d = 1'b0;
               busy_d = 1'b0;
            end
            WAIT_WRITE: begin
               if (iWriteSample) begin
                  busy_d = 1'b1;
                  if (count_q < target_q) begin
                     state_d = CAPTURE;
                  end else begin
                     ovf_d   = 1'b1;
                     next_d  = 1'b1;
                     state_d = ACK;
                  end
               end
            end
            CAPTURE: begin
               for (int c = 0; c < NUM_CHANNELS; c++) begin
                  for (int l = 0; l < LANES; l++) begin
                     if (CW'(l) < n_take) begin
                        wr_off = WO_W'(slot_offset(c, int'(count_q) + l, NUM_SAMPLES, SAMPLE_W));
                        rd_off = RO_W'(slot_offset(c, l, LANES, SAMPLE_W));
                        samples_d[wr_off +: SAMPLE_W] = iLaneData[rd_off +: SAMPLE_W];
                     end
                  end
               end
               count_d    = count_q + n_take;
               checksum_d = checksum_q + lane_sum;
               done_d     = ((count_q + n_take) == target_q);
               next_d     = 1'b1;
               busy_d     = 1'b1;
               state_d    = ACK;
            end
            ACK: begin
               if (!iWriteSample) begin
                  next_d  = 1'b0;
                  busy_d  = 1'b0;
                  state_d = WAIT_WRITE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge iClock or negedge iReset_n) begin
      if (!iReset_n) begin
         state_q      <= IDLE;
         start_prev_q <= 1'b0;
         target_q     <= FULL_C;
         count_q      <= '0;
         samples_q    <= '0;
         checksum_q   <= '0;
         done_q       <= 1'b0;
         ovf_q        <= 1'b0;
         next_q       <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         start_prev_q <= start_prev_d;
         target_q     <= target_d;
         count_q      <= count_d;
         samples_q    <= samples_d;
         checksum_q   <= checksum_d;
         done_q       <= done_d;
         ovf_q        <= ovf_d;
         next_q       <= next_d;
         busy_q       <= busy_d;
      end
   end

   assign oNextSample          = next_q;
   assign oPreparingNextSample = busy_q;
   assign oSamples             = samples_q;
   assign oSampleCount         = count_q[CNT_W-1:0];
   assign oDone                = done_q;
   assign oOverflow            = ovf_q;
   assign oChecksum            = checksum_q;

endmodule
